// File: rtl/mreg_pkg.sv
// ============================================================================
// Module      : mreg_pkg
// Description : Shared definitions for the mul_reg loader: default widths,
//               state encodings and the weight-word width macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef MREG_PKG_SV
`define MREG_PKG_SV

// Total bits in a fixed-point weight word.
`define MREG_WORD_W(i, f) ((i) + (f))

package mreg_pkg;

    localparam int DEF_I_WIDTH = 8;
    localparam int DEF_F_WIDTH = 8;
    localparam int DEF_N       = 3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLR   = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_FLUSH = 3'd3;
    localparam logic [2:0] ST_RUN   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_CLR   = ST_CLR,
        S_LOAD  = ST_LOAD,
        S_FLUSH = ST_FLUSH,
        S_RUN   = ST_RUN
    } state_t;

endpackage

`endif

`default_nettype wire

// File: rtl/mreg_loader_if.sv
// ============================================================================
// Module      : mreg_loader_if
// Description : Control, weight-stream and mul_reg signal bundle of the
//               loader. master = controlling side, slave = the loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mreg_loader_if
    import mreg_pkg::*;
#(
    parameter int I_WIDTH     = DEF_I_WIDTH,
    parameter int F_WIDTH     = DEF_F_WIDTH,
    parameter int N           = DEF_N,
    parameter int ADDRS_WIDTH = $clog2(N),
    parameter int CNT_WIDTH   = $clog2(N + 1)
);

    logic                                         start_i;
    logic [CNT_WIDTH-1:0]                         num_w_i;
    logic                                         clr_i;
    logic signed [`MREG_WORD_W(I_WIDTH, F_WIDTH)-1:0] w_data_i;
    logic                                         w_valid_i;
    logic                                         w_ready_o;
    logic                                         run_en_i;
    logic                                         mreg_rst_o;
    logic                                         mreg_wr_en_o;
    logic [ADDRS_WIDTH-1:0]                       mreg_wr_addrs_o;
    logic signed [`MREG_WORD_W(I_WIDTH, F_WIDTH)-1:0] wr_data_o;
    logic [ADDRS_WIDTH-1:0]                       mreg_rd_addrs_o;
    logic                                         rd_valid_o;
    logic                                         last_o;
    logic                                         loaded_o;

    modport master (
        output start_i, num_w_i, clr_i, w_data_i, w_valid_i, run_en_i,
        input  w_ready_o, mreg_rst_o, mreg_wr_en_o, mreg_wr_addrs_o, wr_data_o,
               mreg_rd_addrs_o, rd_valid_o, last_o, loaded_o
    );

    modport slave (
        input  start_i, num_w_i, clr_i, w_data_i, w_valid_i, run_en_i,
        output w_ready_o, mreg_rst_o, mreg_wr_en_o, mreg_wr_addrs_o, wr_data_o,
               mreg_rd_addrs_o, rd_valid_o, last_o, loaded_o
    );

endinterface

`default_nettype wire

// File: rtl/mreg_wrap_cnt.sv
// ============================================================================
// Module      : mreg_wrap_cnt
// Description : Loadable up-counter that returns to 0 after reaching a
//               programmable limit; wrap is high on the enabled cycle in
//               which count == limit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mreg_wrap_cnt #(
    parameter int WIDTH = 2
) (
    input  wire logic             clk_i,
    input  wire logic             rst_n_i,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] load_val,
    input  wire logic             en,
    input  wire logic [WIDTH-1:0] limit,
    output logic      [WIDTH-1:0] count,
    output logic                  wrap
);

    assign wrap = en && (count == limit);

    // Load has priority over counting; counting wraps at the limit.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= wrap ? '0 : count + WIDTH'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/mreg_loader.sv
// ============================================================================
// Module      : mreg_loader
// Description : Clears the mul_reg file, writes a stream of weights to
//               consecutive addresses, then cycles the read address over the
//               stored weights.
//               Optional feature macro: MREG_ZERO_SKIP_EN (zero words are
//               accepted but not written).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mreg_loader
    import mreg_pkg::*;
#(
    parameter int I_WIDTH     = DEF_I_WIDTH,
    parameter int F_WIDTH     = DEF_F_WIDTH,
    parameter int N           = DEF_N,
    parameter int ADDRS_WIDTH = $clog2(N),
    parameter int CNT_WIDTH   = $clog2(N + 1)
) (
    input  wire logic    clk_i,
    input  wire logic    rst_n_i,
    mreg_loader_if.slave bus
);

    localparam int W = `MREG_WORD_W(I_WIDTH, F_WIDTH);

    state_t                 state;
    logic [CNT_WIDTH-1:0]   num_lat;
    logic [CNT_WIDTH-1:0]   acc_cnt;
    logic [CNT_WIDTH-1:0]   wcnt;
    logic                   ready;
    logic                   mrst;
    logic                   wr_en;
    logic                   loaded;
    logic                   rd_valid;
    logic [ADDRS_WIDTH-1:0] wr_addr;
    logic signed [W-1:0]    wr_data;

    logic                   hs;
    logic                   do_write;
    logic                   start_ok;
    logic [CNT_WIDTH-1:0]   num_clamp;
    logic [CNT_WIDTH-1:0]   nstored;
    logic [CNT_WIDTH-1:0]   nstored_m1;
    logic [ADDRS_WIDTH-1:0] rptr;
    logic                   rd_load;
    logic                   rd_en;
    logic                   wrap;

    assign hs        = ready && bus.w_valid_i;
    assign start_ok  = bus.start_i && (bus.num_w_i != '0);
    assign num_clamp = (bus.num_w_i > CNT_WIDTH'(N)) ? CNT_WIDTH'(N) : bus.num_w_i;

`ifdef MREG_ZERO_SKIP_EN
    // Zero words consume a handshake but occupy no register.
    assign do_write = hs && (bus.w_data_i != '0);
    assign nstored  = wcnt;
`else
    assign do_write = hs;
    assign nstored  = num_lat;
`endif

    assign nstored_m1 = nstored - CNT_WIDTH'(1);

    // Read pointer holds 0 outside RUN and is reset when a reload wins over run_en.
    assign rd_load = (state != S_RUN) || start_ok;
    assign rd_en   = bus.run_en_i && rd_valid;

    mreg_wrap_cnt #(
        .WIDTH (ADDRS_WIDTH)
    ) u_rptr (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .load     (rd_load),
        .load_val ('0),
        .en       (rd_en),
        .limit    (nstored_m1[ADDRS_WIDTH-1:0]),
        .count    (rptr),
        .wrap     (wrap)
    );

    // Load/run sequencer with registered mul_reg controls.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= S_IDLE;
            num_lat  <= '0;
            acc_cnt  <= '0;
            wcnt     <= '0;
            ready    <= 1'b0;
            mrst     <= 1'b0;
            wr_en    <= 1'b0;
            loaded   <= 1'b0;
            rd_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else if (bus.clr_i) begin
            state    <= S_IDLE;
            num_lat  <= '0;
            acc_cnt  <= '0;
            wcnt     <= '0;
            ready    <= 1'b0;
            mrst     <= 1'b0;
            wr_en    <= 1'b0;
            loaded   <= 1'b0;
            rd_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            mrst  <= 1'b0;
            wr_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        num_lat <= num_clamp;
                        acc_cnt <= '0;
                        wcnt    <= '0;
                        mrst    <= 1'b1;
                        state   <= S_CLR;
                    end
                end
                S_CLR: begin
                    ready <= 1'b1;
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    if (hs) begin
                        if (do_write) begin
                            wr_en   <= 1'b1;
                            wr_addr <= wcnt[ADDRS_WIDTH-1:0];
                            wr_data <= bus.w_data_i;
                            wcnt    <= wcnt + CNT_WIDTH'(1);
                        end
                        acc_cnt <= acc_cnt + CNT_WIDTH'(1);
                        if ((acc_cnt + CNT_WIDTH'(1)) == num_lat) begin
                            ready <= 1'b0;
                            state <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    loaded   <= 1'b1;
                    rd_valid <= (nstored != '0);
                    state    <= S_RUN;
                end
                S_RUN: begin
                    if (start_ok) begin
                        num_lat  <= num_clamp;
                        acc_cnt  <= '0;
                        wcnt     <= '0;
                        loaded   <= 1'b0;
                        rd_valid <= 1'b0;
                        mrst     <= 1'b1;
                        state    <= S_CLR;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.w_ready_o       = ready;
    assign bus.mreg_rst_o      = mrst;
    assign bus.mreg_wr_en_o    = wr_en;
    assign bus.mreg_wr_addrs_o = wr_addr;
    assign bus.wr_data_o       = wr_data;
    assign bus.mreg_rd_addrs_o = (state == S_RUN) ? rptr : '0;
    assign bus.rd_valid_o      = rd_valid;
    assign bus.last_o          = wrap;
    assign bus.loaded_o        = loaded;

endmodule

`default_nettype wire

// File: tb/tb_mreg_loader.sv
// ============================================================================
// Module      : tb_mreg_loader
// Description : Self-checking bench for mreg_loader (N=3, 3-bit word count).
//               Honours MREG_ZERO_SKIP_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mreg_loader;

    localparam int N      = 3;
    localparam int CNT_W  = 3;
    localparam int ADDR_W = 2;
    localparam int W      = 16;
`ifdef MREG_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mreg_loader_if #(.I_WIDTH(8), .F_WIDTH(8), .N(N), .CNT_WIDTH(CNT_W)) bus ();

    mreg_loader #(
        .I_WIDTH   (8),
        .F_WIDTH   (8),
        .N         (N),
        .CNT_WIDTH (CNT_W)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] stim_q[$];
    int           model_ns = 0;
    int           model_rp = 0;

    // {w_ready, mreg_rst, mreg_wr_en, loaded, rd_valid}
    function automatic logic [4:0] status();
        return {bus.w_ready_o, bus.mreg_rst_o, bus.mreg_wr_en_o, bus.loaded_o, bus.rd_valid_o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start_i   = 1'b0;
        bus.num_w_i   = '0;
        bus.clr_i     = 1'b0;
        bus.w_data_i  = '0;
        bus.w_valid_i = 1'b0;
        bus.run_en_i  = 1'b0;
    endtask

    // Start a load of num words from stim_q and follow it into RUN.
    task automatic run_load(input int num, input bit gaps);
        int           n_acc;
        int           acc;
        int           cyc;
        bit           pend;
        bit           v;
        int           pend_addr;
        logic [W-1:0] pend_data;
        logic [W-1:0] d;
        logic [W-1:0] stored[$];
        n_acc = (num > N) ? N : num;
        acc   = 0;
        cyc   = 0;
        pend  = 1'b0;
        pend_addr = 0;
        pend_data = '0;
        stored.delete();
        bus.run_en_i  = 1'b0;
        bus.w_valid_i = 1'b0;
        bus.start_i   = 1'b1;
        bus.num_w_i   = CNT_W'(num);
        tick();
        bus.start_i = 1'b0;
        @(negedge clk);
        checks++;
        if (status() !== 5'b01000) begin
            failures++;
            $display("FAIL clr_pulse: status=%b want 01000", status());
        end
        tick();
        while (acc < n_acc && cyc < 100) begin
            v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            d = stim_q[acc];
            bus.w_valid_i = v;
            bus.w_data_i  = d;
            @(negedge clk);
            checks++;
            if (status() !== {1'b1, 1'b0, pend, 2'b00}) begin
                failures++;
                $display("FAIL load_status: status=%b want %b", status(), {1'b1, 1'b0, pend, 2'b00});
            end
            if (pend) begin
                checks++;
                if (bus.mreg_wr_addrs_o !== ADDR_W'(pend_addr) || bus.wr_data_o !== pend_data) begin
                    failures++;
                    $display("FAIL load_write: addr=%0d data=%h want addr=%0d data=%h",
                             bus.mreg_wr_addrs_o, bus.wr_data_o, pend_addr, pend_data);
                end
            end
            tick();
            pend = 1'b0;
            if (v) begin
                if (!SKIP || d != '0) begin
                    pend      = 1'b1;
                    pend_addr = stored.size();
                    pend_data = d;
                    stored.push_back(d);
                end
                acc++;
            end
            cyc++;
        end
        if (acc < n_acc) begin
            checks++;
            failures++;
            $display("FAIL load_budget: accepted=%0d want %0d", acc, n_acc);
        end
        // Offer one more word; it must not be taken.
        bus.w_valid_i = 1'b1;
        bus.w_data_i  = (acc < stim_q.size()) ? stim_q[acc] : 16'h1234;
        @(negedge clk);
        checks++;
        if (status() !== {1'b0, 1'b0, pend, 2'b00}) begin
            failures++;
            $display("FAIL flush_status: status=%b want %b", status(), {1'b0, 1'b0, pend, 2'b00});
        end
        if (pend) begin
            checks++;
            if (bus.mreg_wr_addrs_o !== ADDR_W'(pend_addr) || bus.wr_data_o !== pend_data) begin
                failures++;
                $display("FAIL flush_write: addr=%0d data=%h want addr=%0d data=%h",
                         bus.mreg_wr_addrs_o, bus.wr_data_o, pend_addr, pend_data);
            end
        end
        tick();
        model_ns = stored.size();
        model_rp = 0;
        @(negedge clk);
        checks++;
        if (status() !== {3'b000, 1'b1, model_ns != 0} || bus.mreg_rd_addrs_o !== '0) begin
            failures++;
            $display("FAIL run_entry: status=%b rd=%0d want %b rd=0",
                     status(), bus.mreg_rd_addrs_o, {3'b000, 1'b1, model_ns != 0});
        end
        tick();
        bus.w_valid_i = 1'b0;
        if (model_ns != 0) model_rp = 0;
    endtask

    // Drive run_en for a number of RUN cycles and follow the modular read pointer.
    task automatic run_read(input int cycles, input bit hold);
        bit exp_last;
        for (int i = 0; i < cycles; i++) begin
            bus.run_en_i = hold ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clk);
            exp_last = bus.run_en_i && (model_ns != 0) && (model_rp == model_ns - 1);
            checks++;
            if (bus.mreg_rd_addrs_o !== ADDR_W'(model_rp) || bus.last_o !== exp_last ||
                bus.rd_valid_o !== (model_ns != 0) || bus.loaded_o !== 1'b1) begin
                failures++;
                $display("FAIL read: rd=%0d last=%b rdv=%b ld=%b want rd=%0d last=%b rdv=%b ld=1",
                         bus.mreg_rd_addrs_o, bus.last_o, bus.rd_valid_o, bus.loaded_o,
                         model_rp, exp_last, model_ns != 0);
            end
            tick();
            if (bus.run_en_i && model_ns != 0) model_rp = (model_rp + 1) % model_ns;
        end
        bus.run_en_i = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (status() !== 5'b0 || bus.mreg_wr_addrs_o !== '0 || bus.wr_data_o !== '0 ||
            bus.mreg_rd_addrs_o !== '0 || bus.last_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: status=%b want 00000", status());
        end
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (status() !== 5'b0) begin
            failures++;
            $display("FAIL idle_after_reset: status=%b want 00000", status());
        end
    endtask

    task automatic test_ignore_zero_start();
        bus.start_i = 1'b1;
        bus.num_w_i = '0;
        tick();
        bus.start_i = 1'b0;
        @(negedge clk);
        checks++;
        if (status() !== 5'b0) begin
            failures++;
            $display("FAIL zero_start: status=%b want 00000", status());
        end
        tick();
    endtask

    task automatic test_back_to_back();
        stim_q = {16'd5, 16'hFFFE, 16'd7, 16'd1};
        run_load(3, 1'b0);
    endtask

    task automatic test_clamp();
        stim_q = {16'd11, 16'd22, 16'd33, 16'd44, 16'd55};
        run_load(5, 1'b0);
        run_read(4, 1'b1);
    endtask

    task automatic test_read_wrap();
        stim_q = {16'h0101, 16'h0202, 16'h0303};
        run_load(2, 1'b0);
        run_read(4, 1'b1);
    endtask

    task automatic test_start_beats_run();
        // A start with zero count is ignored, so reading continues.
        bus.start_i = 1'b1;
        bus.num_w_i = '0;
        run_read(1, 1'b1);
        bus.start_i = 1'b0;
        bus.start_i  = 1'b1;
        bus.num_w_i  = CNT_W'(2);
        bus.run_en_i = 1'b1;
        tick();
        bus.start_i  = 1'b0;
        bus.run_en_i = 1'b0;
        @(negedge clk);
        checks++;
        if (status() !== 5'b01000 || bus.mreg_rd_addrs_o !== '0) begin
            failures++;
            $display("FAIL start_beats_run: status=%b rd=%0d want 01000 rd=0",
                     status(), bus.mreg_rd_addrs_o);
        end
        tick();
        bus.clr_i = 1'b1;
        tick();
        bus.clr_i = 1'b0;
        @(negedge clk);
        checks++;
        if (status() !== 5'b0) begin
            failures++;
            $display("FAIL clr_abort: status=%b want 00000", status());
        end
        tick();
    endtask

    task automatic test_zero_words();
        stim_q = {16'd0, 16'd9, 16'd0, 16'd4};
        run_load(3, 1'b0);
        run_read(4, 1'b1);
    endtask

    task automatic test_random();
        logic [W-1:0] wv;
        for (int it = 0; it < 8; it++) begin
            stim_q.delete();
            for (int k = 0; k < 6; k++) begin
                wv = W'($urandom);
                if ($urandom_range(0, 3) == 0) wv = '0;
                stim_q.push_back(wv);
            end
            run_load($urandom_range(1, 5), 1'b1);
            run_read(8, 1'b0);
        end
    endtask

    task automatic test_reset_mid_load();
        stim_q = {16'd3, 16'd4, 16'd5};
        bus.start_i = 1'b1;
        bus.num_w_i = CNT_W'(3);
        tick();
        bus.start_i = 1'b0;
        tick();
        bus.w_valid_i = 1'b1;
        bus.w_data_i  = stim_q[0];
        tick();
        bus.w_valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (status() !== 5'b10100) begin
            failures++;
            $display("FAIL pre_reset_write: status=%b want 10100", status());
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (status() !== 5'b0 || bus.mreg_wr_addrs_o !== '0 || bus.wr_data_o !== '0 ||
            bus.mreg_rd_addrs_o !== '0 || bus.last_o !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: status=%b data=%h want 00000 data=0", status(), bus.wr_data_o);
        end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (status() !== 5'b0) begin
            failures++;
            $display("FAIL idle_after_mid_reset: status=%b want 00000", status());
        end
    endtask

    initial begin
        test_reset();
        test_ignore_zero_start();
        test_back_to_back();
        test_clamp();
        test_read_wrap();
        test_start_beats_run();
        test_zero_words();
        test_random();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
